regfile_read_stage: RTL and testbench

Registered two-port read stage for the 32 x 64-bit register file: it samples two register indices, selects their contents from the file's parallel outputs, and presents them one cycle later with a valid flag. It sits between the register file and the execute stage. A write-to-read bypass ensures that a read issued in the same cycle as a write to the same register returns the new data. Index 31 is the hardwired zero register and always reads 0.

---
 rtl/regfile_read_stage.sv | 63 ++++++
 tb/tb_regfile_read_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: registered two-port register-file read with write bypass and stall refresh.
module regfile_read_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] regs [31:0],
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [63:0] wr_data,
    input  logic        rd_req,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        stall,
    output logic [63:0] rd1,
    output logic [63:0] rd2,
    output logic        rd_valid,
    output logic        byp1,
    output logic        byp2
);
    logic [4:0]  cap1, cap2;
    logic [63:0] sel1, sel2;
    logic        hit1, hit2, ref1, ref2;

    always_comb begin
        hit1 = wr_en && wr_addr == ra1 && ra1 != 5'd31;
        hit2 = wr_en && wr_addr == ra2 && ra2 != 5'd31;
        sel1 = ra1 == 5'd31 ? 64'd0 : hit1 ? wr_data : regs[ra1];
        sel2 = ra2 == 5'd31 ? 64'd0 : hit2 ? wr_data : regs[ra2];
        // a held result is kept coherent with writes landing during a stall
        ref1 = rd_valid && wr_en && wr_addr == cap1 && cap1 != 5'd31;
        ref2 = rd_valid && wr_en && wr_addr == cap2 && cap2 != 5'd31;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap1     <= 5'd31;
            cap2     <= 5'd31;
            rd1      <= '0;
            rd2      <= '0;
            rd_valid <= 1'b0;
            byp1     <= 1'b0;
            byp2     <= 1'b0;
        end else if (stall) begin
            if (ref1) begin
                rd1  <= wr_data;
                byp1 <= 1'b1;
            end
            if (ref2) begin
                rd2  <= wr_data;
                byp2 <= 1'b1;
            end
        end else if (rd_req) begin
            cap1     <= ra1;
            cap2     <= ra2;
            rd1      <= sel1;
            rd2      <= sel2;
            byp1     <= hit1;
            byp2     <= hit2;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_read_stage.sv
// tb_regfile_read_stage: directed vectors with hand-computed expectations.
module tb_regfile_read_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] regs [31:0];
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_req;
    logic [4:0]  ra1, ra2;
    logic        stall;
    logic [63:0] rd1, rd2;
    logic        rd_valid, byp1, byp2;
    int          checks = 0;
    int          errors = 0;

    regfile_read_stage dut (
        .clk(clk), .reset(reset), .regs(regs), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req(rd_req), .ra1(ra1), .ra2(ra2), .stall(stall),
        .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid), .byp1(byp1), .byp2(byp2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] e1, input logic [63:0] e2,
                             input logic ev, input logic eb1, input logic eb2);
        check({tag, ".rd1"}, rd1, e1);
        check({tag, ".rd2"}, rd2, e2);
        check({tag, ".valid"}, {63'd0, rd_valid}, {63'd0, ev});
        check({tag, ".byp1"}, {63'd0, byp1}, {63'd0, eb1});
        check({tag, ".byp2"}, {63'd0, byp2}, {63'd0, eb2});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_req = 0; ra1 = 0; ra2 = 0; stall = 0;
        #1;
        check_out("reset", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;

        // reset mid-operation
        regs[3] = 27; regs[4] = 44;
        rd_req = 1; ra1 = 3; ra2 = 4;
        step();
        check_out("pre_rst", 27, 44, 1, 0, 0);
        rd_req = 0;
        #2 reset = 1'b1;
        #1 check_out("async_rst", 0, 0, 0, 0, 0);
        #1 reset = 1'b0;

        // basic read then idle
        regs[4] = 27; regs[0] = 64'd2147483647;
        rd_req = 1; ra1 = 4; ra2 = 0;
        step();
        check_out("basic", 27, 64'd2147483647, 1, 0, 0);
        rd_req = 0;
        step();
        check_out("idle", 27, 64'd2147483647, 0, 0, 0);

        // same-cycle write bypass
        wr_en = 1; wr_addr = 4; wr_data = 44;
        rd_req = 1; ra1 = 4; ra2 = 4;
        step();
        check_out("bypass", 44, 44, 1, 1, 1);

        // zero register ignores writes
        regs[5] = 16; wr_addr = 31; wr_data = 1;
        ra1 = 31; ra2 = 5;
        step();
        check_out("zero", 0, 16, 1, 0, 0);

        // stall with refresh on port 1 only
        wr_en = 0; regs[7] = 5; regs[8] = 6; regs[9] = 77;
        ra1 = 7; ra2 = 8;
        step();
        check_out("st_acc", 5, 6, 1, 0, 0);
        stall = 1; ra1 = 9;
        step();
        check_out("stall1", 5, 6, 1, 0, 0);
        wr_en = 1; wr_addr = 7; wr_data = 99;
        step();
        check_out("stall2", 99, 6, 1, 1, 0);
        wr_en = 0;
        step();
        check_out("stall3", 99, 6, 1, 1, 0);
        stall = 0;
        step();
        check_out("unstall", 77, 6, 1, 0, 0);

        // refresh of both ports on a shared index; index 31 never refreshes
        ra1 = 2; ra2 = 2; regs[2] = 3;
        step();
        stall = 1; wr_en = 1; wr_addr = 2; wr_data = 55;
        step();
        check_out("st_both", 55, 55, 1, 1, 1);
        stall = 0; wr_en = 0; ra1 = 31; ra2 = 31;
        step();
        stall = 1; wr_en = 1; wr_addr = 31; wr_data = 5;
        step();
        check_out("st_zero", 0, 0, 1, 0, 0);

        // no refresh while not valid
        stall = 0; wr_en = 0; ra1 = 6; ra2 = 31; regs[6] = 12;
        step();
        rd_req = 0;
        step();
        stall = 1; wr_en = 1; wr_addr = 6; wr_data = 88;
        step();
        check_out("st_inval", 12, 0, 0, 0, 0);
        stall = 0; wr_en = 0;

        // back-to-back
        for (int i = 1; i <= 4; i++) regs[i] = 64'(10 * i);
        rd_req = 1; ra2 = 0;
        for (int i = 1; i <= 4; i++) begin
            ra1 = 5'(i);
            step();
            check_out("b2b", 64'(10 * i), 64'd2147483647, 1, 0, 0);
        end
        rd_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
